// File: rtl/noc_pkg.sv
// Shared flit layout, direction encoding and node-ID helpers for the mesh NoC.
package noc_pkg;

    localparam int FLIT_W    = 64;
    localparam int ADDR_W    = 16;
    localparam int PAYLOAD_W = 32;
    localparam int NUM_PORTS = 5;

    localparam int DST_HI = 63;
    localparam int DST_LO = 48;
    localparam int SRC_HI = 47;
    localparam int SRC_LO = 32;
    localparam int PAY_HI = 31;
    localparam int PAY_LO = 0;

    // Input index and output index share this encoding.
    typedef enum logic [2:0] {
        DIR_L     = 3'd0,
        DIR_R     = 3'd1,
        DIR_U     = 3'd2,
        DIR_D     = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

    typedef struct packed {
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] col;
    } rc_t;

    function automatic rc_t id_to_rc(input logic [ADDR_W-1:0] id, input int unsigned mesh_w);
        int unsigned idx;
        rc_t         rc;
        idx    = 32'(id) - 32'd1;
        rc.row = ADDR_W'(idx / mesh_w);
        rc.col = ADDR_W'(idx % mesh_w);
        return rc;
    endfunction

    function automatic logic [ADDR_W-1:0] rc_to_id(input rc_t rc, input int unsigned mesh_w);
        return ADDR_W'(32'(rc.row) * mesh_w + 32'(rc.col) + 32'd1);
    endfunction

endpackage

// File: rtl/mesh_router_xy_route.sv
// Dimension-ordered (X then Y) route decision for one flit at this node.
module xy_route
    import noc_pkg::*;
#(
    parameter int MESH_W = 3,
    parameter int MESH_H = 3
) (
    input  logic [ADDR_W-1:0] my_addr_i,
    input  logic [FLIT_W-1:0] flit_i,
    output logic              vld_o,
    output dir_e              dir_o
);

    localparam int unsigned NUM_NODES = MESH_W * MESH_H;

    logic [ADDR_W-1:0] dst_s;
    rc_t               my_rc_s;
    rc_t               dst_rc_s;

    assign dst_s    = flit_i[DST_HI:DST_LO];
    assign my_rc_s  = id_to_rc(my_addr_i, MESH_W);
    assign dst_rc_s = id_to_rc(dst_s, MESH_W);

    // Validity window and X-first direction choice.
    always_comb begin
        vld_o = (dst_s >= 16'd1) && (32'(dst_s) <= NUM_NODES);
        if (dst_rc_s.col > my_rc_s.col) begin
            dir_o = DIR_R;
        end else if (dst_rc_s.col < my_rc_s.col) begin
            dir_o = DIR_L;
        end else if (dst_rc_s.row > my_rc_s.row) begin
            dir_o = DIR_D;
        end else if (dst_rc_s.row < my_rc_s.row) begin
            dir_o = DIR_U;
        end else begin
            dir_o = DIR_LOCAL;
        end
    end

endmodule

// File: rtl/mesh_router.sv
// Five-port mesh router: per-input hold register, fixed-priority per-output arbitration.
module mesh_router
    import noc_pkg::*;
#(
    parameter int MESH_W = 3,
    parameter int MESH_H = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_W-1:0]    in_left,
    input  logic [FLIT_W-1:0]    in_right,
    input  logic [FLIT_W-1:0]    in_up,
    input  logic [FLIT_W-1:0]    in_down,
    input  logic [PAYLOAD_W-1:0] from_cpu,
    input  logic [ADDR_W-1:0]    my_addr,
    input  logic [ADDR_W-1:0]    dest_addr,
    output logic [FLIT_W-1:0]    out_left,
    output logic [FLIT_W-1:0]    out_right,
    output logic [FLIT_W-1:0]    out_up,
    output logic [FLIT_W-1:0]    out_down,
    output logic [PAYLOAD_W-1:0] to_cpu,
    input  logic                 set_fi
);

    logic [NUM_PORTS-1:0][FLIT_W-1:0] fresh_s;
    logic [NUM_PORTS-1:0][FLIT_W-1:0] cand_s;
    logic [NUM_PORTS-1:0]             cand_vld_s;
    dir_e                             cand_dir_s [NUM_PORTS];
    logic [NUM_PORTS-1:0]             won_s;

    logic [NUM_PORTS-1:0][FLIT_W-1:0] hold_q, hold_d;
    logic [NUM_PORTS-1:0]             hold_vld_q, hold_vld_d;
    logic [NUM_PORTS-1:0][FLIT_W-1:0] out_d;
    logic [NUM_PORTS-1:0]             out_vld_d;
    logic [3:0][FLIT_W-1:0]           out_q;
    logic [PAYLOAD_W-1:0]             to_cpu_q, to_cpu_d;

    assign fresh_s[int'(DIR_L)]     = in_left;
    assign fresh_s[int'(DIR_R)]     = in_right;
    assign fresh_s[int'(DIR_U)]     = in_up;
    assign fresh_s[int'(DIR_D)]     = in_down;
    assign fresh_s[int'(DIR_LOCAL)] = set_fi ? {dest_addr, my_addr, from_cpu} : {FLIT_W{1'b0}};

    // A held flit shadows the fresh one, which is then lost.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_route
        assign cand_s[g] = hold_vld_q[g] ? hold_q[g] : fresh_s[g];
        xy_route #(
            .MESH_W (MESH_W),
            .MESH_H (MESH_H)
        ) u_xy_route (
            .my_addr_i (my_addr),
            .flit_i    (cand_s[g]),
            .vld_o     (cand_vld_s[g]),
            .dir_o     (cand_dir_s[g])
        );
    end

    // Independent fixed-priority grant per output, lowest input index first.
    always_comb begin
        logic found;
        out_d     = '0;
        out_vld_d = '0;
        won_s     = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            found = 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && cand_vld_s[i] && (cand_dir_s[i] == dir_e'(o))) begin
                    found        = 1'b1;
                    out_d[o]     = cand_s[i];
                    out_vld_d[o] = 1'b1;
                    won_s[i]     = 1'b1;
                end else begin
                    found = found;
                end
            end
        end
    end

    // Valid losers park in (or stay in) their hold; winners and invalid flits leave.
    always_comb begin
        hold_d     = cand_s;
        hold_vld_d = cand_vld_s & ~won_s;
        if (out_vld_d[int'(DIR_LOCAL)]) begin
            to_cpu_d = out_d[int'(DIR_LOCAL)][PAY_HI:PAY_LO];
        end else begin
            to_cpu_d = to_cpu_q;
        end
    end

    // Registered outputs, holds and CPU payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= '0;
            out_q      <= '0;
            to_cpu_q   <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            out_q      <= out_d[3:0];
            to_cpu_q   <= to_cpu_d;
        end
    end

    assign out_left  = out_q[int'(DIR_L)];
    assign out_right = out_q[int'(DIR_R)];
    assign out_up    = out_q[int'(DIR_U)];
    assign out_down  = out_q[int'(DIR_D)];
    assign to_cpu    = to_cpu_q;

endmodule

// File: tb/tb_mesh_router.sv
// Directed bench for mesh_router: routing, delivery, injection, contention, drops, reset.
module tb_mesh_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_left, in_right, in_up, in_down;
    logic [31:0] from_cpu;
    logic [15:0] my_addr, dest_addr;
    logic [63:0] out_left, out_right, out_up, out_down;
    logic [31:0] to_cpu;
    logic        set_fi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mesh_router #(.MESH_W(3), .MESH_H(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_up     (in_up),
        .in_down   (in_down),
        .from_cpu  (from_cpu),
        .my_addr   (my_addr),
        .dest_addr (dest_addr),
        .out_left  (out_left),
        .out_right (out_right),
        .out_up    (out_up),
        .out_down  (out_down),
        .to_cpu    (to_cpu),
        .set_fi    (set_fi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [63:0] l, input logic [63:0] r,
                            input logic [63:0] u, input logic [63:0] d);
        chk({tag, "_left"},  out_left,  l);
        chk({tag, "_right"}, out_right, r);
        chk({tag, "_up"},    out_up,    u);
        chk({tag, "_down"},  out_down,  d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_left  = 64'h0;
        in_right = 64'h0;
        in_up    = 64'h0;
        in_down  = 64'h0;
        set_fi   = 1'b0;
        from_cpu = 32'h0;
    endtask

    initial begin
        rst       = 1'b1;
        my_addr   = 16'd5;
        dest_addr = 16'd0;
        idle_inputs();
        tick();
        chk_outs("reset", 64'h0, 64'h0, 64'h0, 64'h0);
        chk("reset_cpu", {32'h0, to_cpu}, 64'h0);
        rst = 1'b0;

        // Straight pass west->east at node 5.
        in_left = 64'h0006_0004_DEADBEEF;
        tick();
        chk_outs("pass", 64'h0, 64'h0006_0004_DEADBEEF, 64'h0, 64'h0);
        idle_inputs();
        tick();
        chk("pass_gone", out_right, 64'h0);

        // Local delivery, then hold of to_cpu while idle.
        in_up = 64'h0005_0002_CAFEF00D;
        tick();
        chk("local", {32'h0, to_cpu}, 64'h0000_0000_CAFEF00D);
        chk_outs("local", 64'h0, 64'h0, 64'h0, 64'h0);
        idle_inputs();
        tick();
        tick();
        chk("local_keep", {32'h0, to_cpu}, 64'h0000_0000_CAFEF00D);

        // Injection from node 1: to 9 goes right, to 4 goes down.
        my_addr   = 16'd1;
        dest_addr = 16'd9;
        set_fi    = 1'b1;
        from_cpu  = 32'h12345678;
        tick();
        chk_outs("inj9", 64'h0, 64'h0009_0001_12345678, 64'h0, 64'h0);
        dest_addr = 16'd4;
        tick();
        chk_outs("inj4", 64'h0, 64'h0, 64'h0, 64'h0004_0001_12345678);
        idle_inputs();

        // Contention on out_down; a second fresh flit on held in_up is lost.
        my_addr = 16'd5;
        in_left = 64'h0008_0004_11111111;
        in_up   = 64'h0008_0002_22222222;
        tick();
        chk("cont_n1", out_down, 64'h0008_0004_11111111);
        in_left = 64'h0;
        in_up   = 64'h0008_0002_33333333;
        tick();
        chk("cont_n2", out_down, 64'h0008_0002_22222222);
        in_up = 64'h0;
        tick();
        chk("cont_drop2nd", out_down, 64'h0);

        // Out-of-range and empty destinations are dropped.
        in_left  = 64'h000A_0004_AAAA5555;
        in_right = 64'h0000_0006_5555AAAA;
        tick();
        chk_outs("drop", 64'h0, 64'h0, 64'h0, 64'h0);
        chk("drop_cpu", {32'h0, to_cpu}, 64'h0000_0000_CAFEF00D);
        idle_inputs();

        // Three inputs to three different outputs in one cycle.
        in_left  = 64'h0006_0004_0000000A;
        in_right = 64'h0004_0006_0000000B;
        in_down  = 64'h0002_0008_0000000C;
        tick();
        chk_outs("multi", 64'h0004_0006_0000000B, 64'h0006_0004_0000000A,
                 64'h0002_0008_0000000C, 64'h0);
        idle_inputs();

        // Reset while a flit is held discards it.
        in_left = 64'h0008_0004_44440000;
        in_up   = 64'h0008_0002_44444444;
        tick();
        chk("rstmid_win", out_down, 64'h0008_0004_44440000);
        idle_inputs();
        rst = 1'b1;
        tick();
        chk_outs("rstmid", 64'h0, 64'h0, 64'h0, 64'h0);
        chk("rstmid_cpu", {32'h0, to_cpu}, 64'h0);
        rst = 1'b0;
        tick();
        chk("rstmid_nohold", out_down, 64'h0);
        tick();
        chk("rstmid_nohold2", out_down, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
